// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int DEF_DW        = 8;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_BURST_MAX = 4;

  localparam int OWNER_W = 3;
  localparam int CNT_W   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or above rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    index,
  output logic             any
);

  localparam logic [IW:0] N_L = (IW+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then
  // rotate the offset back into an absolute index modulo N_REQ.
  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= N_L) sum = sum - N_L;
    index = sum[IW-1:0];
    any   = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates N_REQ word sources onto one FIFO write port in bursts.
//
// Handshake: req[i] is the valid of requester i and data slice i is its word;
// the word is consumed in a cycle where ack[i] is high. A requester must hold
// req and its word stable until it sees ack, then may present the next word or
// drop req. ack is combinational (same cycle as wen) and never asserts while
// full is high.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   data,
  output logic [N_REQ-1:0]      ack,
  input  logic                  full,
  output logic                  wen,
  output logic [DW-1:0]         wdata,
  output logic [OWNER_W-1:0]    owner,
  output logic                  busy,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

  arb_state_t       state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [BW-1:0]    burst_q;
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] stall_count_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    nxt_ptr;
  logic             owner_req;
  logic             do_write;
  logic [DW-1:0]    data_arr [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Split the flat data bus into per-requester words.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = data[i*DW +: DW];
    end
  end

  assign busy      = (state_q == GRANT);
  assign owner_req = req[owner_q];
  assign do_write  = busy && owner_req && !full;
  assign nxt_ptr   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  assign wen         = do_write;
  assign wdata       = busy ? data_arr[owner_q] : '0;
  assign owner       = OWNER_W'(owner_q);
  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;

  // ack is wen decoded onto the owner, so at most one bit is ever set.
  always_comb begin
    ack = '0;
    if (do_write) ack[owner_q] = 1'b1;
  end

  // Arbitration FSM with burst and statistics counters; every exit from
  // GRANT passes through one IDLE cycle where the next owner is picked.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      burst_q       <= '0;
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_idx;
            burst_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state_q  <= IDLE;
            rr_ptr_q <= nxt_ptr;
          end else if (full) begin
            stall_count_q <= sat_inc(stall_count_q);
          end else begin
            wr_count_q <= sat_inc(wr_count_q);
            burst_q    <= burst_q + 1'b1;
            if (burst_q == BURST_LAST) begin
              state_q  <= IDLE;
              rr_ptr_q <= nxt_ptr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario, inline checks.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int N_REQ = 4;
  localparam int BURST_MAX = 4;

  logic                wclk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    ack;
  logic                full;
  logic                wen;
  logic [DW-1:0]       wdata;
  logic [2:0]          owner;
  logic                busy;
  logic [15:0]         wr_count;
  logic [15:0]         stall_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  // Clock / reset block
  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .DW        (DW),
    .N_REQ     (N_REQ),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .wclk        (wclk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .full        (full),
    .wen         (wen),
    .wdata       (wdata),
    .owner       (owner),
    .busy        (busy),
    .wr_count    (wr_count),
    .stall_count (stall_count)
  );

  // Driver: hold reset for two cycles with all inputs quiet, release on negedge.
  task automatic apply_reset();
    rst = 1'b0; req = '0; full = 1'b0; data = '0;
    @(negedge wclk);
    @(negedge wclk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'hF; full = 1'b0; data = 32'hDEADBEEF;
    @(negedge wclk); #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", wen); end
    n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
    n_checks++; if (owner !== 3'd0) begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
    // First grant after release goes to the lowest active requester.
    @(negedge wclk); rst = 1'b1; req = 4'b1010;
    @(negedge wclk); #1;
    n_checks++; if (owner !== 3'd1) begin n_fail++; $display("FAIL first_grant_owner got=%0d exp=1", owner); end
    n_checks++; if (wen !== 1'b1) begin n_fail++; $display("FAIL first_grant_wen got=%b exp=1", wen); end
    n_checks++; if (wdata !== 8'hBE) begin n_fail++; $display("FAIL first_grant_wdata got=%h exp=be", wdata); end
  endtask

  task automatic test_single_burst();
    int k;
    int nw;
    logic exp_wen [9];
    exp_wen = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    k = 0; nw = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge wclk);
      req = (k < 6) ? 4'b0001 : 4'b0000;
      data = '0;
      data[7:0] = 8'(160 + k);
      #1;
      n_checks++; if (wen !== exp_wen[c]) begin n_fail++; $display("FAIL single_wen c=%0d got=%b exp=%b", c, wen, exp_wen[c]); end
      if (exp_wen[c]) begin
        n_checks++; if (wdata !== 8'(160 + nw)) begin n_fail++; $display("FAIL single_wdata c=%0d got=%h exp=%h", c, wdata, 8'(160 + nw)); end
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack c=%0d got=%b exp=0001", c, ack); end
        nw++;
      end else begin
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_idle c=%0d got=%b exp=0000", c, ack); end
      end
      if (c == 0 || c == 5) begin
        n_checks++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL single_idle_wdata c=%0d got=%h exp=00", c, wdata); end
      end
      if (ack[0]) k++;
    end
    @(negedge wclk); #1;
    n_checks++; if (wr_count !== 16'd6) begin n_fail++; $display("FAIL single_wr_count got=%0d exp=6", wr_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int seq [4];
    int exp_seq [4];
    int eo;
    logic exp_w;
    apply_reset();
    for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    for (int c = 0; c < 32; c++) begin
      @(negedge wclk);
      req = 4'hF;
      for (int i = 0; i < 4; i++) data[i*8 +: 8] = 8'(i * 16 + seq[i]);
      #1;
      exp_w = ((c % 5) != 0);
      eo = (c / 5) % 4;
      n_checks++; if (wen !== exp_w) begin n_fail++; $display("FAIL rr_wen c=%0d got=%b exp=%b", c, wen, exp_w); end
      n_checks++; if ($countones(ack) > 1) begin n_fail++; $display("FAIL rr_onehot c=%0d got=%b exp=at_most_one", c, ack); end
      if (exp_w) begin
        n_checks++; if (owner !== 3'(eo)) begin n_fail++; $display("FAIL rr_owner c=%0d got=%0d exp=%0d", c, owner, eo); end
        n_checks++; if (ack !== 4'(1 << eo)) begin n_fail++; $display("FAIL rr_ack c=%0d got=%b exp=%b", c, ack, 4'(1 << eo)); end
        n_checks++; if (wdata !== 8'(eo * 16 + exp_seq[eo])) begin n_fail++; $display("FAIL rr_wdata c=%0d got=%h exp=%h", c, wdata, 8'(eo * 16 + exp_seq[eo])); end
        exp_seq[eo]++;
      end else begin
        n_checks++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL rr_idle_wdata c=%0d got=%h exp=00", c, wdata); end
      end
      for (int i = 0; i < 4; i++) if (ack[i]) seq[i]++;
    end
  endtask

  task automatic test_stall();
    int seq2;
    logic fp [11];
    logic exp_wen [11];
    logic [DW-1:0] e;
    fp      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_wen = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(32 + i));
    seq2 = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge wclk);
      req = 4'b0100;
      full = fp[c];
      data = '0;
      data[23:16] = 8'(32 + seq2);
      #1;
      n_checks++; if (wen !== exp_wen[c]) begin n_fail++; $display("FAIL stall_wen c=%0d got=%b exp=%b", c, wen, exp_wen[c]); end
      n_checks++; if (wen && full) begin n_fail++; $display("FAIL stall_overflow c=%0d got=wen_with_full exp=no_write", c); end
      if (exp_wen[c]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_sb_empty c=%0d got=write exp=none", c);
        end else begin
          e = exp_q.pop_front();
          if (wdata !== e) begin n_fail++; $display("FAIL stall_wdata c=%0d got=%h exp=%h", c, wdata, e); end
        end
      end
      if (fp[c]) begin
        n_checks++; if (owner !== 3'd2 || busy !== 1'b1 || ack !== 4'b0) begin
          n_fail++; $display("FAIL stall_hold c=%0d got=owner%0d busy%b ack%b exp=owner2 busy1 ack0000", c, owner, busy, ack);
        end
      end
      if (ack[2]) seq2++;
    end
    @(negedge wclk); full = 1'b0; req = 4'b0000; #1;
    n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL stall_count got=%0d exp=5", stall_count); end
    n_checks++; if (wr_count !== 16'd4) begin n_fail++; $display("FAIL stall_wr_count got=%0d exp=4", wr_count); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_lost_words got=%0d exp=0", exp_q.size()); end
  endtask

  // Bench-side model of an 8-deep write FIFO with no reader.
  task automatic test_fifo_fill();
    int occ;
    apply_reset();
    occ = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wclk);
      req = 4'hF;
      full = (occ >= 8);
      data = 32'h44332211;
      #1;
      n_checks++; if (wen && full) begin n_fail++; $display("FAIL fill_overflow c=%0d got=wen_with_full exp=no_write", c); end
      if (wen) occ++;
    end
    @(negedge wclk); full = (occ >= 8); #1;
    n_checks++; if (occ != 8) begin n_fail++; $display("FAIL fill_writes got=%0d exp=8", occ); end
    n_checks++; if (wr_count !== 16'd8) begin n_fail++; $display("FAIL fill_wr_count got=%0d exp=8", wr_count); end
    n_checks++; if (stall_count !== 16'd9) begin n_fail++; $display("FAIL fill_stall_count got=%0d exp=9", stall_count); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    @(negedge wclk); req = 4'b0001; data = '0; data[7:0] = 8'h55; #1;
    @(negedge wclk); #1;
    n_checks++; if (wen !== 1'b1) begin n_fail++; $display("FAIL midrst_word1 got=%b exp=1", wen); end
    @(negedge wclk); #1;
    n_checks++; if (wen !== 1'b1) begin n_fail++; $display("FAIL midrst_word2 got=%b exp=1", wen); end
    rst = 1'b0; #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL midrst_wen got=%b exp=0", wen); end
    n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL midrst_ack got=%b exp=0000", ack); end
    n_checks++; if (busy !== 1'b0 || wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_busy_wdata got=%b/%h exp=0/00", busy, wdata); end
    n_checks++; if (wr_count !== 16'd0 || stall_count !== 16'd0) begin n_fail++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", wr_count, stall_count); end
    @(negedge wclk); rst = 1'b1; req = 4'b1100; data = 32'h77665544;
    @(negedge wclk); #1;
    n_checks++; if (owner !== 3'd2) begin n_fail++; $display("FAIL midrst_regrant_owner got=%0d exp=2", owner); end
    n_checks++; if (wen !== 1'b1 || wdata !== 8'h66) begin n_fail++; $display("FAIL midrst_regrant_write got=%b/%h exp=1/66", wen, wdata); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL midrst_regrant_count got=%0d exp=0", wr_count); end
  endtask

  task automatic test_req_drop();
    apply_reset();
    data = 32'h33221100;
    @(negedge wclk); req = 4'b0010; #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL drop_arb_wen got=%b exp=0", wen); end
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      n_checks++; if (wen !== 1'b1 || owner !== 3'd1) begin n_fail++; $display("FAIL drop_write c=%0d got=%b/%0d exp=1/1", c, wen, owner); end
    end
    @(negedge wclk); req = 4'b0100; #1;
    n_checks++; if (wen !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL drop_nowrite got=%b/%b exp=0/1", wen, busy); end
    @(negedge wclk); req = 4'b0110; #1;
    n_checks++; if (busy !== 1'b0 || wen !== 1'b0) begin n_fail++; $display("FAIL drop_idle got=%b/%b exp=0/0", busy, wen); end
    n_checks++; if (wr_count !== 16'd2) begin n_fail++; $display("FAIL drop_wr_count got=%0d exp=2", wr_count); end
    @(negedge wclk); #1;
    n_checks++; if (owner !== 3'd2) begin n_fail++; $display("FAIL drop_next_owner got=%0d exp=2", owner); end
    n_checks++; if (ack !== 4'b0100 || wdata !== 8'h22) begin n_fail++; $display("FAIL drop_next_write got=%b/%h exp=0100/22", ack, wdata); end
  endtask

  initial begin
    rst = 1'b0; req = '0; full = 1'b0; data = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_fifo_fill();
    test_reset_mid_burst();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DW, default 8: data width; matches the asynfifo write port width.
REQ-002 Parameter N_REQ, default 4: number of requesters; the range is 2..8.
REQ-003 Parameter BURST_MAX, default 4: the most words one owner may write per grant.
REQ-004 wclk  input  1  single clock: the FIFO write-domain clock.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 req  input  N_REQ  per-requester request: requester i has a word ready.
REQ-007 data  input  N_REQ*DW  per-requester word: slice i is data of requester i.
REQ-008 ack  output  N_REQ  one-hot accept: the word of requester i is written this cycle.
REQ-009 full  input  1  FIFO full flag, from the write domain.
REQ-010 wen  output  1  FIFO write enable.
REQ-011 wdata  output  DW  FIFO write data.
REQ-012 owner  output  3  index of the currently granted requester.
REQ-013 busy  output  1  high when the FSM is in GRANT.
REQ-014 wr_count  output  16  saturating count of words written since reset.
REQ-015 stall_count  output  16  saturating count of cycles stalled on full.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-017 IDLE, any req high: latch owner = first requester with req high, searching upward from rr_ptr with wrap; next state GRANT; burst_cnt=0.
REQ-018 IDLE, no req: remain in IDLE; wen=0; ack=0.
REQ-019 GRANT, req[owner]=1 and full=0 -> wen=1, ack[owner]=1, wdata=data[owner] in the same cycle (combinational, zero latency); burst_cnt increments.
REQ-020 GRANT, req[owner]=1 and full=1 -> stall: wen=0, ack=0, burst_cnt held, stall_count increments, remain in GRANT.
REQ-021 GRANT, req[owner]=0 -> no write; next state IDLE; rr_ptr=(owner+1) mod N_REQ.
REQ-022 GRANT, a write that brings burst_cnt to BURST_MAX -> next state IDLE; rr_ptr=(owner+1) mod N_REQ.
REQ-023 Every GRANT->IDLE return SHALL cost exactly one idle arbitration cycle (wen=0) before the next grant.
REQ-024 wen SHALL never be high while full is high, so the FIFO overflow flag never asserts.
REQ-025 At most one ack bit SHALL be high in any cycle, and ack SHALL equal wen decoded to owner.
REQ-026 Requests from non-owners SHALL be ignored until rearbitration; no requester may be starved beyond (N_REQ-1) grants.
REQ-027 wr_count and stall_count SHALL stop at 16'hFFFF and not wrap.
REQ-028 Outside GRANT, wdata SHALL be 0.

Reset
REQ-029 rst low SHALL force, asynchronously: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, wr_count=0, stall_count=0.
REQ-030 During reset, wen=0, ack=0, busy=0 and wdata=0.
REQ-031 Reset asserted mid-burst SHALL drop wen in the same cycle; any partial burst is abandoned.
REQ-032 After rst deasserts, the first grant SHALL go to the lowest-indexed active requester.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default constants DW, N_REQ and BURST_MAX.
REQ-034 Sub-module rr_pick (combinational rotate-priority picker: inputs req and rr_ptr; outputs index and any) SHALL perform the owner selection.
REQ-035 The FSM, the counters and the output muxing SHALL live in fifo_wr_arbiter.

Verification
REQ-036 req=4'b0001, full=0, data0=8'hA0..A5 -> writes A0..A3 on consecutive cycles, 1 idle cycle, then A4,A5; wr_count=6.
REQ-037 req=4'b1111 held for 32 cycles -> owners follow 0,1,2,3,0 in order, 4 words each; ack is one-hot; no starvation.
REQ-038 owner=2 mid-burst with full forced high for 5 cycles -> wen=0 for those 5 cycles, stall_count=5, the burst resumes with owner 2 and no lost or duplicate words.
REQ-039 Connect the block to asynfifo #(8,8) (wclk 10 ns period, rclk 14 ns), with no reads -> exactly 8 writes reach the FIFO, then stalls begin; overflow never asserts.
REQ-040 rst pulled low during the 2nd word of a burst -> wen=0 immediately; after release, req=4'b1100 gives the grant to 2; counters read 0.
REQ-041 req[1] drops after 2 of 4 words -> GRANT->IDLE, rr_ptr=2; the next grant goes to 2 (if requesting), not 1.
